memstage: RTL and testbench

- Memory-access stage of the rv32i 5-stage pipeline, directly downstream of the execute stage.
- Consumes the ALU result (address or value), the decoded instruction and the rs2 store data.
- Performs loads and stores over a req/ack data-memory port and stalls upstream while a transaction is outstanding.
- Forwards a registered result and instruction to writeback.

---
 rtl/memstage_if.sv | 32 +++
 rtl/memstage.sv | 161 ++++++++++++++++
 tb/tb_memstage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/memstage_if.sv
// memstage_pkg / memstage_dmem_if: decoded-instruction type and the req/ack data-memory bus.
// Rev 1.0 - initial release.
`default_nettype none

package memstage_pkg;
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic [2:0] f3;
  } instruction_t;
endpackage

interface memstage_dmem_if;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    input  dmem_ack_i, dmem_rdata_i
  );
  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

`default_nettype wire

// File: rtl/memstage.sv
// memstage: rv32i memory-access stage, one outstanding req/ack transaction, stalls upstream while BUSY.
// Optional macro MEMSTAGE_MISALIGN_TRAP_EN adds misaligned_o trapping. Rev 1.0 - initial release.
`default_nettype none

module memstage
  import memstage_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         valid_i,
  input  instruction_t instruction_i,
  input  logic [31:0]  result_i,
  input  logic [31:0]  store_data_i,
  output logic         stall_o,
  memstage_dmem_if.master dmem,
  output logic         valid_o,
  output logic [31:0]  result_o,
  output instruction_t instruction_o
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  ,
  output logic         misaligned_o
`endif
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic         r_valid;
  logic         r_mis;
  logic [31:0]  r_result;
  instruction_t r_instr;
  logic         r_we;
  logic [31:0]  r_addr;
  logic [3:0]   r_be;
  logic [31:0]  r_wdata;
  logic [1:0]   r_off;

  logic         w_is_mem;
  logic         w_byte;
  logic         w_half;
  logic         w_word;
  logic         w_mis;
  logic [1:0]   w_off;
  logic [3:0]   w_be;
  logic [31:0]  w_wdata;
  logic [7:0]   w_ld_byte;
  logic [15:0]  w_ld_half;
  logic [31:0]  w_ld_data;

  // Stores only know SB/SH/SW; loads fold the unsigned variants onto the same sizes.
  assign w_is_mem = instruction_i.is_load | instruction_i.is_store;
  assign w_off    = result_i[1:0];
  assign w_byte   = instruction_i.is_store ? (instruction_i.f3 == 3'b000)
                                           : (instruction_i.f3[1:0] == 2'b00);
  assign w_half   = instruction_i.is_store ? (instruction_i.f3 == 3'b001)
                                           : (instruction_i.f3[1:0] == 2'b01);
  assign w_word   = !w_byte && !w_half;

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign w_mis = w_is_mem && ((w_half && w_off[0]) || (w_word && (w_off != 2'b00)));
`else
  assign w_mis = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data_i;
    if (w_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{store_data_i[7:0]}};
    end else if (w_half) begin
      w_be    = w_off[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{store_data_i[15:0]}};
    end
  end

  assign w_ld_byte = dmem.dmem_rdata_i[8*r_off +: 8];
  assign w_ld_half = r_off[1] ? dmem.dmem_rdata_i[31:16] : dmem.dmem_rdata_i[15:0];

  always_comb begin
    w_ld_data = dmem.dmem_rdata_i;
    case (r_instr.f3)
      3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
      3'b100:  w_ld_data = {24'd0, w_ld_byte};
      3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
      3'b101:  w_ld_data = {16'd0, w_ld_half};
      default: w_ld_data = dmem.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (valid_i && w_is_mem && !w_mis) w_state_nxt = S_BUSY;
      S_BUSY:  if (dmem.dmem_ack_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid  <= 1'b0;
      r_mis    <= 1'b0;
      r_result <= '0;
      r_instr  <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_off    <= '0;
    end else begin
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (valid_i) begin
          r_instr  <= instruction_i;
          r_result <= result_i;
          if (w_is_mem && !w_mis) begin
            r_we    <= instruction_i.is_store;
            r_addr  <= {result_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_off   <= w_off;
          end else begin
            r_valid <= 1'b1;
            r_mis   <= w_mis;
          end
        end
      end else if (dmem.dmem_ack_i) begin
        r_valid <= 1'b1;
        if (!r_instr.is_store) r_result <= w_ld_data;
      end
    end
  end

  assign stall_o           = (r_state == S_BUSY);
  assign dmem.dmem_req_o   = (r_state == S_BUSY);
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_be_o    = r_be;
  assign dmem.dmem_wdata_o = r_wdata;
  assign valid_o           = r_valid;
  assign result_o          = r_result;
  assign instruction_o     = r_instr;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  assign misaligned_o      = r_mis;
`endif

endmodule

`default_nettype wire

// File: tb/tb_memstage.sv
// tb_memstage: table-driven directed bench for memstage plus hand-written reset/ack/misalign sequences.
`default_nettype none

module tb_memstage;
  import memstage_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         valid_i;
  instruction_t instruction_i;
  logic [31:0]  result_i;
  logic [31:0]  store_data_i;
  logic         stall_o;
  logic         valid_o;
  logic [31:0]  result_o;
  instruction_t instruction_o;
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
  logic         misaligned_o;
`endif

  memstage_dmem_if dmem ();

  memstage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .valid_i       (valid_i),
    .instruction_i (instruction_i),
    .result_i      (result_i),
    .store_data_i  (store_data_i),
    .stall_o       (stall_o),
    .dmem          (dmem.master),
    .valid_o       (valid_o),
    .result_o      (result_o),
    .instruction_o (instruction_o)
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    ,
    .misaligned_o  (misaligned_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        is_load;
    logic        is_store;
    logic [2:0]  f3;
    logic [31:0] res;
    logic [31:0] sd;
    logic [31:0] rd;
    int          busy;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_res;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] res, input logic [31:0] sd,
                              input logic [31:0] rd, input int busy,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_res);
    vec_t v;
    v.is_load = ld;  v.is_store = st; v.f3 = f3;
    v.res = res;     v.sd = sd;       v.rd = rd;  v.busy = busy;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_res = e_res;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_op(input vec_t v, input string tag);
    logic [31:0] e_ins;
    e_ins = {27'd0, v.is_load, v.is_store, v.f3};
    valid_i                 = 1'b1;
    instruction_i.is_load   = v.is_load;
    instruction_i.is_store  = v.is_store;
    instruction_i.f3        = v.f3;
    result_i                = v.res;
    store_data_i            = v.sd;
    tick();
    valid_i = 1'b0;
    if (v.busy == 0) begin
      check({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, ".result"}, result_o, v.e_res);
      check({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
      check({tag, ".req"}, {31'd0, dmem.dmem_req_o}, 32'd0);
    end else begin
      check({tag, ".valid_busy"}, {31'd0, valid_o}, 32'd0);
      for (int k = 1; k <= v.busy; k++) begin
        check({tag, ".stall_busy"}, {31'd0, stall_o}, 32'd1);
        check({tag, ".req_busy"}, {31'd0, dmem.dmem_req_o}, 32'd1);
        check({tag, ".we"}, {31'd0, dmem.dmem_we_o}, {31'd0, v.is_store});
        check({tag, ".addr"}, dmem.dmem_addr_o, v.e_addr);
        check({tag, ".be"}, {28'd0, dmem.dmem_be_o}, {28'd0, v.e_be});
        if (v.is_store) check({tag, ".wdata"}, dmem.dmem_wdata_o, v.e_wdata);
        if (k == v.busy) begin
          dmem.dmem_ack_i   = 1'b1;
          dmem.dmem_rdata_i = v.rd;
        end
        tick();
      end
      dmem.dmem_ack_i   = 1'b0;
      dmem.dmem_rdata_i = 32'h0;
      check({tag, ".valid"}, {31'd0, valid_o}, 32'd1);
      check({tag, ".result"}, result_o, v.e_res);
      check({tag, ".stall_done"}, {31'd0, stall_o}, 32'd0);
      check({tag, ".req_done"}, {31'd0, dmem.dmem_req_o}, 32'd0);
    end
    check({tag, ".instr"}, {27'd0, instruction_o}, e_ins);
`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    check({tag, ".misaligned"}, {31'd0, misaligned_o}, 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [13];
    vec_t v;

    //             ld st  f3      res           sd            rd            bsy addr          be       wdata         result
    vecs[0]  = mk(0, 0, 3'b000, 32'h0000_0042, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0000_0042);
    vecs[1]  = mk(1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_FF00, 3, 32'h0000_1000, 4'b1000, 32'h0,        32'hFFFF_FF80);
    vecs[2]  = mk(0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        1, 32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 32'h0000_2002);
    vecs[3]  = mk(1, 0, 3'b101, 32'h0000_0000, 32'h0,        32'h0000_8001, 1, 32'h0000_0000, 4'b0011, 32'h0,        32'h0000_8001);
    vecs[4]  = mk(1, 0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8001, 1, 32'h0000_0000, 4'b0011, 32'h0,        32'hFFFF_8001);
    vecs[5]  = mk(0, 1, 3'b000, 32'h0000_1001, 32'h0000_00A5, 32'h0,        2, 32'h0000_1000, 4'b0010, 32'hA5A5_A5A5, 32'h0000_1001);
    vecs[6]  = mk(0, 1, 3'b010, 32'h0000_4000, 32'hDEAD_BEEF, 32'h0,        1, 32'h0000_4000, 4'b1111, 32'hDEAD_BEEF, 32'h0000_4000);
    vecs[7]  = mk(1, 0, 3'b010, 32'h0000_4004, 32'h0,        32'hCAFE_F00D, 2, 32'h0000_4004, 4'b1111, 32'h0,        32'hCAFE_F00D);
    vecs[8]  = mk(1, 0, 3'b100, 32'h0000_1002, 32'h0,        32'h12AB_3456, 1, 32'h0000_1000, 4'b0100, 32'h0,        32'h0000_00AB);
    vecs[9]  = mk(1, 0, 3'b001, 32'h0000_0002, 32'h0,        32'h9ABC_0011, 1, 32'h0000_0000, 4'b1100, 32'h0,        32'hFFFF_9ABC);
    vecs[10] = mk(0, 1, 3'b100, 32'h0000_5000, 32'h1122_3344, 32'h0,        1, 32'h0000_5000, 4'b1111, 32'h1122_3344, 32'h0000_5000);
    vecs[11] = mk(1, 0, 3'b110, 32'h0000_5004, 32'h0,        32'h5566_7788, 1, 32'h0000_5004, 4'b1111, 32'h0,        32'h5566_7788);
    vecs[12] = mk(0, 0, 3'b111, 32'hFFFF_FFFF, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'hFFFF_FFFF);

    rst_i             = 1'b1;
    valid_i           = 1'b0;
    instruction_i     = '0;
    result_i          = 32'h0;
    store_data_i      = 32'h0;
    dmem.dmem_ack_i   = 1'b0;
    dmem.dmem_rdata_i = 32'h0;
    tick();
    tick();
    rst_i = 1'b0;

    check("rst.valid", {31'd0, valid_o}, 32'd0);
    check("rst.stall", {31'd0, stall_o}, 32'd0);
    check("rst.req", {31'd0, dmem.dmem_req_o}, 32'd0);
    check("rst.we", {31'd0, dmem.dmem_we_o}, 32'd0);
    check("rst.be", {28'd0, dmem.dmem_be_o}, 32'd0);
    check("rst.addr", dmem.dmem_addr_o, 32'd0);
    check("rst.result", result_o, 32'd0);
    check("rst.instr", {27'd0, instruction_o}, 32'd0);

    // Consecutive calls present the next op in the cycle valid_o rises.
    for (int i = 0; i < 13; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Idle cycle then an ack with nothing outstanding.
    tick();
    check("idle.valid", {31'd0, valid_o}, 32'd0);
    dmem.dmem_ack_i   = 1'b1;
    dmem.dmem_rdata_i = 32'h7777_7777;
    tick();
    dmem.dmem_ack_i = 1'b0;
    check("idle_ack.valid", {31'd0, valid_o}, 32'd0);
    check("idle_ack.stall", {31'd0, stall_o}, 32'd0);
    check("idle_ack.req", {31'd0, dmem.dmem_req_o}, 32'd0);

    // Reset while BUSY, then a late ack.
    valid_i                = 1'b1;
    instruction_i.is_load  = 1'b1;
    instruction_i.is_store = 1'b0;
    instruction_i.f3       = 3'b010;
    result_i               = 32'h0000_6000;
    tick();
    valid_i = 1'b0;
    check("rstbusy.stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i             = 1'b0;
    dmem.dmem_ack_i   = 1'b1;
    dmem.dmem_rdata_i = 32'h1234_5678;
    check("rstbusy.req", {31'd0, dmem.dmem_req_o}, 32'd0);
    check("rstbusy.valid", {31'd0, valid_o}, 32'd0);
    tick();
    dmem.dmem_ack_i   = 1'b0;
    dmem.dmem_rdata_i = 32'h0;
    check("lateack.valid", {31'd0, valid_o}, 32'd0);
    check("lateack.stall", {31'd0, stall_o}, 32'd0);
    check("lateack.result", result_o, 32'd0);
    check("lateack.instr", {27'd0, instruction_o}, 32'd0);

    // After reset the stage still services a normal op.
    run_op(vecs[7], "post_rst");

`ifdef MEMSTAGE_MISALIGN_TRAP_EN
    valid_i                = 1'b1;
    instruction_i.is_load  = 1'b1;
    instruction_i.is_store = 1'b0;
    instruction_i.f3       = 3'b010;
    result_i               = 32'h0000_3001;
    tick();
    valid_i = 1'b0;
    check("mis_lw.req", {31'd0, dmem.dmem_req_o}, 32'd0);
    check("mis_lw.stall", {31'd0, stall_o}, 32'd0);
    check("mis_lw.valid", {31'd0, valid_o}, 32'd1);
    check("mis_lw.misaligned", {31'd0, misaligned_o}, 32'd1);
    check("mis_lw.result", result_o, 32'h0000_3001);
    tick();
    check("mis_lw.valid_after", {31'd0, valid_o}, 32'd0);
    check("mis_lw.mis_after", {31'd0, misaligned_o}, 32'd0);
    valid_i                = 1'b1;
    instruction_i.is_load  = 1'b0;
    instruction_i.is_store = 1'b1;
    instruction_i.f3       = 3'b001;
    result_i               = 32'h0000_2003;
    tick();
    valid_i = 1'b0;
    check("mis_sh.req", {31'd0, dmem.dmem_req_o}, 32'd0);
    check("mis_sh.misaligned", {31'd0, misaligned_o}, 32'd1);
    check("mis_sh.result", result_o, 32'h0000_2003);
`else
    v = mk(1, 0, 3'b010, 32'h0000_3001, 32'h0, 32'hA1B2_C3D4, 1, 32'h0000_3000, 4'b1111, 32'h0, 32'hA1B2_C3D4);
    run_op(v, "unal_lw");
    v = mk(1, 0, 3'b001, 32'h0000_0003, 32'h0, 32'h8123_0000, 1, 32'h0000_0000, 4'b1100, 32'h0, 32'hFFFF_8123);
    run_op(v, "unal_lh");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
